// File: rtl/cc_miss_ar_scheduler.sv
// Miss refill AR scheduler: pops miss addresses, issues one 8-beat WRAP burst per miss,
// caps in-flight bursts and watches the R channel for retirement and protocol errors.
module cc_miss_ar_scheduler #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [3:0]  ARID            = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_empty_i,
  input  logic [31:0] miss_addr_i,
  output logic        miss_rden_o,
  output logic [3:0]  mem_arid_o,
  output logic [31:0] mem_araddr_o,
  output logic [3:0]  mem_arlen_o,
  output logic [2:0]  mem_arsize_o,
  output logic [1:0]  mem_arburst_o,
  output logic        mem_arvalid_o,
  input  logic        mem_arready_i,
  input  logic        mem_rvalid_i,
  input  logic        mem_rready_i,
  input  logic        mem_rlast_i,
  input  logic [1:0]  mem_rresp_i,
  output logic [1:0]  outstanding_o,
  output logic [2:0]  beat_cnt_o,
  output logic        err_o,
  input  logic        err_clr_i
);

  localparam logic [1:0] MAX_OUT = 2'(MAX_OUTSTANDING);

  typedef enum logic {S_IDLE, S_ISSUE} state_e;

  state_e      state_q, state_d;
  logic [31:0] araddr_q, araddr_d;
  logic [1:0]  outstanding_q, outstanding_d;
  logic [2:0]  beat_q, beat_d;
  logic        err_q, err_d;
  logic        pop, ar_hs, r_hs, retire, err_set;

  assign pop    = (state_q == S_IDLE) && !rst && !miss_empty_i && (outstanding_q < MAX_OUT);
  assign ar_hs  = (state_q == S_ISSUE) && mem_arready_i;
  assign r_hs   = mem_rvalid_i && mem_rready_i;
  // A stray rlast with nothing in flight must not underflow the counter.
  assign retire = r_hs && mem_rlast_i && (outstanding_q != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pop)   state_d = S_ISSUE;
      S_ISSUE: if (ar_hs) state_d = S_IDLE;
      default:            state_d = S_IDLE;
    endcase
  end

  always_comb begin
    miss_rden_o   = pop;
    mem_arvalid_o = (state_q == S_ISSUE);
  end

  always_comb begin
    araddr_d = araddr_q;
    if (pop) araddr_d = {miss_addr_i[31:3], 3'b000};

    outstanding_d = outstanding_q;
    case ({ar_hs, retire})
      2'b10:   outstanding_d = outstanding_q + 2'd1;
      2'b01:   outstanding_d = outstanding_q - 2'd1;
      default: outstanding_d = outstanding_q;
    endcase

    beat_d = beat_q;
    if (r_hs) begin
      if (mem_rlast_i)          beat_d = '0;
      else if (beat_q != 3'd7)  beat_d = beat_q + 3'd1;
    end

    err_set = r_hs && ((mem_rresp_i != 2'b00) ||
                       (mem_rlast_i && (beat_q != 3'd7)) ||
                       (!mem_rlast_i && (beat_q == 3'd7)) ||
                       (outstanding_q == 2'd0));
    err_d = err_q;
    if (err_set)        err_d = 1'b1;
    else if (err_clr_i) err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      araddr_q      <= '0;
      outstanding_q <= '0;
      beat_q        <= '0;
      err_q         <= 1'b0;
    end else begin
      araddr_q      <= araddr_d;
      outstanding_q <= outstanding_d;
      beat_q        <= beat_d;
      err_q         <= err_d;
    end
  end

  assign mem_arid_o    = ARID;
  assign mem_araddr_o  = araddr_q;
  assign mem_arlen_o   = 4'd7;
  assign mem_arsize_o  = 3'd3;
  assign mem_arburst_o = 2'b10;
  assign outstanding_o = outstanding_q;
  assign beat_cnt_o    = beat_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_cc_miss_ar_scheduler.sv
// Scoreboard bench for cc_miss_ar_scheduler: directed scenarios followed by random traffic,
// checked every cycle against a behavioural model of the burst and error bookkeeping.
module tb_cc_miss_ar_scheduler;

  localparam int MAX_OUT_TB = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_empty_i = 1'b1;
  logic [31:0] miss_addr_i = '0;
  logic        miss_rden_o;
  logic [3:0]  mem_arid_o;
  logic [31:0] mem_araddr_o;
  logic [3:0]  mem_arlen_o;
  logic [2:0]  mem_arsize_o;
  logic [1:0]  mem_arburst_o;
  logic        mem_arvalid_o;
  logic        mem_arready_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic        mem_rready_i = 1'b0;
  logic        mem_rlast_i = 1'b0;
  logic [1:0]  mem_rresp_i = 2'b00;
  logic [1:0]  outstanding_o;
  logic [2:0]  beat_cnt_o;
  logic        err_o;
  logic        err_clr_i = 1'b0;

  cc_miss_ar_scheduler #(.MAX_OUTSTANDING(MAX_OUT_TB), .ARID(4'd0)) dut (
    .clk(clk), .rst(rst),
    .miss_empty_i(miss_empty_i), .miss_addr_i(miss_addr_i), .miss_rden_o(miss_rden_o),
    .mem_arid_o(mem_arid_o), .mem_araddr_o(mem_araddr_o), .mem_arlen_o(mem_arlen_o),
    .mem_arsize_o(mem_arsize_o), .mem_arburst_o(mem_arburst_o),
    .mem_arvalid_o(mem_arvalid_o), .mem_arready_i(mem_arready_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rready_i(mem_rready_i), .mem_rlast_i(mem_rlast_i),
    .mem_rresp_i(mem_rresp_i), .outstanding_o(outstanding_o), .beat_cnt_o(beat_cnt_o),
    .err_o(err_o), .err_clr_i(err_clr_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  logic [31:0] fifo[$];
  logic [31:0] exp_q[$];
  bit pop_seen = 1'b0;
  int ar_cnt = 0;

  // Model state: AR request pending, bursts in flight, beats seen, sticky error.
  bit m_pending = 1'b0;
  int m_out = 0;
  int m_beat = 0;
  bit m_err = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin : monitor
    bit exp_rden, r_hs, set_err;
    int nout;
    exp_rden = !rst && !m_pending && !miss_empty_i && (m_out < MAX_OUT_TB);
    if (chk_en) begin
      chk("miss_rden", {31'd0, miss_rden_o}, {31'd0, exp_rden});
      chk("arvalid", {31'd0, mem_arvalid_o}, {31'd0, m_pending});
      chk("outstanding", {30'd0, outstanding_o}, 32'(m_out));
      chk("beat_cnt", {29'd0, beat_cnt_o}, 32'(m_beat));
      chk("err", {31'd0, err_o}, {31'd0, m_err});
      chk("ar_const", {19'd0, mem_arid_o, mem_arlen_o, mem_arsize_o, mem_arburst_o},
          {19'd0, 4'd0, 4'd7, 3'd3, 2'b10});
      if (m_pending) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL araddr_unexpected actual=0x%08h expected=none", mem_araddr_o);
        end else chk("araddr", mem_araddr_o, exp_q[0]);
      end
    end
    if (miss_rden_o) pop_seen = 1'b1;
    if (rst) begin
      if (m_pending && exp_q.size() > 0) void'(exp_q.pop_front());
      m_pending = 1'b0; m_out = 0; m_beat = 0; m_err = 1'b0;
    end else begin
      r_hs = mem_rvalid_i && mem_rready_i;
      set_err = r_hs && ((mem_rresp_i != 2'b00) || (mem_rlast_i && m_beat != 7) ||
                         (!mem_rlast_i && m_beat == 7) || (m_out == 0));
      nout = m_out;
      if (m_pending && mem_arready_i) begin
        nout++;
        m_pending = 1'b0;
        ar_cnt++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else if (exp_rden) m_pending = 1'b1;
      if (r_hs && mem_rlast_i && m_out > 0) nout--;
      if (r_hs) m_beat = mem_rlast_i ? 0 : ((m_beat == 7) ? 7 : m_beat + 1);
      if (set_err) m_err = 1'b1;
      else if (err_clr_i) m_err = 1'b0;
      m_out = nout;
    end
  end

  task automatic refresh();
    miss_empty_i = (fifo.size() == 0);
    miss_addr_i  = (fifo.size() != 0) ? fifo[0] : '0;
  endtask

  task automatic push_miss(input logic [31:0] a);
    fifo.push_back(a);
    exp_q.push_back({a[31:3], 3'b000});
    refresh();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pop_seen) begin
      pop_seen = 1'b0;
      if (fifo.size() > 0) void'(fifo.pop_front());
    end
    refresh();
  endtask

  task automatic beat(input bit last, input logic [1:0] resp);
    mem_rvalid_i = 1'b1; mem_rready_i = 1'b1; mem_rlast_i = last; mem_rresp_i = resp;
    tick();
    mem_rvalid_i = 1'b0; mem_rready_i = 1'b0; mem_rlast_i = 1'b0; mem_rresp_i = 2'b00;
  endtask

  task automatic burst();
    for (int i = 0; i < 7; i++) beat(1'b0, 2'b00);
    beat(1'b1, 2'b00);
  endtask

  task automatic wait_ar(input int target);
    for (int i = 0; i < 60 && ar_cnt < target; i++) tick();
    if (ar_cnt < target) begin
      checks++; failures++;
      $display("FAIL ar_timeout actual=%0d expected=%0d", ar_cnt, target);
    end
  endtask

  task automatic expect_at_negedge(input string name, input logic [31:0] act_sel,
                                   input logic [31:0] exp);
    @(negedge clk);
    case (act_sel)
      0: chk(name, {30'd0, outstanding_o}, exp);
      1: chk(name, {29'd0, beat_cnt_o}, exp);
      2: chk(name, {31'd0, err_o}, exp);
      3: chk(name, {31'd0, mem_arvalid_o}, exp);
      default: chk(name, mem_araddr_o, exp);
    endcase
  endtask

  task automatic drain();
    mem_arready_i = 1'b1; err_clr_i = 1'b0;
    for (int i = 0; i < 2000 && (fifo.size() != 0 || m_pending || m_out != 0); i++) begin
      mem_rvalid_i = (m_out > 0); mem_rready_i = 1'b1;
      mem_rlast_i = (m_beat == 7); mem_rresp_i = 2'b00;
      tick();
    end
    mem_rvalid_i = 1'b0; mem_rready_i = 1'b0; mem_rlast_i = 1'b0;
    if (fifo.size() != 0 || m_pending || m_out != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=%0d expected=0", m_out);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1;
    tick(); tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Single miss, full 8-beat burst
    mem_arready_i = 1'b1;
    push_miss(32'h0000_1234);
    wait_ar(1);
    expect_at_negedge("single_araddr", 4, 32'h0000_1230);
    expect_at_negedge("single_out", 0, 1);
    burst();
    tick();
    expect_at_negedge("single_done_out", 0, 0);
    expect_at_negedge("single_done_beat", 1, 0);
    expect_at_negedge("single_done_err", 2, 0);

    // AR backpressure
    mem_arready_i = 1'b0;
    base = ar_cnt;
    push_miss(32'h8000_00FF);
    push_miss(32'h0000_0040);
    repeat (6) tick();
    expect_at_negedge("bp_arvalid", 3, 1);
    expect_at_negedge("bp_araddr", 4, 32'h8000_00F8);
    mem_arready_i = 1'b1;
    wait_ar(base + 2);
    burst(); burst();
    tick();

    // Outstanding cap
    base = ar_cnt;
    push_miss(32'h0000_1000); push_miss(32'h0000_2008); push_miss(32'h0000_3010);
    repeat (10) tick();
    expect_at_negedge("cap_out", 0, 2);
    chk("cap_ar_count", 32'(ar_cnt - base), 32'd2);
    burst();
    wait_ar(base + 3);
    tick();
    expect_at_negedge("cap_out_after", 0, 2);
    burst(); burst();
    tick();

    // Retire and issue in the same cycle
    base = ar_cnt;
    push_miss(32'h0000_4444);
    wait_ar(base + 1);
    for (int i = 0; i < 7; i++) beat(1'b0, 2'b00);
    mem_arready_i = 1'b0;
    push_miss(32'h0000_5555);
    for (int i = 0; i < 20 && !m_pending; i++) tick();
    chk("simul_pending", {31'd0, m_pending}, 32'd1);
    mem_arready_i = 1'b1;
    beat(1'b1, 2'b00);
    tick();
    expect_at_negedge("simul_out", 0, 1);
    burst();
    tick();

    // Error detection and clearing
    base = ar_cnt;
    push_miss(32'h0000_6000);
    wait_ar(base + 1);
    for (int i = 0; i < 3; i++) beat(1'b0, 2'b00);
    beat(1'b1, 2'b00);
    expect_at_negedge("early_last_err", 2, 1);
    err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
    expect_at_negedge("err_cleared", 2, 0);
    push_miss(32'h0000_7000);
    wait_ar(base + 2);
    beat(1'b0, 2'b10);
    expect_at_negedge("slverr", 2, 1);
    err_clr_i = 1'b1; beat(1'b0, 2'b10); err_clr_i = 1'b0;
    expect_at_negedge("set_beats_clear", 2, 1);
    for (int i = 0; i < 5; i++) beat(1'b0, 2'b00);
    beat(1'b1, 2'b00);
    err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
    tick();

    // Reset mid-burst, then a stray beat
    base = ar_cnt;
    push_miss(32'h0000_8000);
    wait_ar(base + 1);
    for (int i = 0; i < 3; i++) beat(1'b0, 2'b00);
    rst = 1'b1; tick(); rst = 1'b0;
    expect_at_negedge("rst_out", 0, 0);
    expect_at_negedge("rst_beat", 1, 0);
    expect_at_negedge("rst_arvalid", 3, 0);
    expect_at_negedge("rst_araddr", 4, 0);
    beat(1'b0, 2'b00);
    expect_at_negedge("stray_err", 2, 1);
    expect_at_negedge("stray_out", 0, 0);
    err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      if (fifo.size() < 4 && $urandom_range(0, 99) < 25) push_miss($urandom());
      mem_arready_i = ($urandom_range(0, 99) < 60);
      err_clr_i = ($urandom_range(0, 99) < 8);
      if (m_out > 0) begin
        mem_rvalid_i = ($urandom_range(0, 99) < 70);
        mem_rready_i = ($urandom_range(0, 99) < 80);
        mem_rlast_i  = (m_beat == 7) ^ ($urandom_range(0, 99) < 3);
        mem_rresp_i  = ($urandom_range(0, 99) < 3) ? 2'b10 : 2'b00;
      end else begin
        mem_rvalid_i = ($urandom_range(0, 99) < 2);
        mem_rready_i = 1'b1;
        mem_rlast_i  = 1'($urandom_range(0, 1));
        mem_rresp_i  = 2'b00;
      end
      tick();
    end
    drain();
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
